// File: rtl/tlc_phase_sched.sv
// Purpose : two-approach traffic-signal phase scheduler (A/B green, yellow, all-red),
//           green hold driven by latched vehicle calls with min-green, gap-out, max-out.
// Latency : state, lamps and pmaxout are registered and change together one clock after
//           the deciding effective tick (tk = ptick | ptest).
// Flow    : no backpressure; sensors are sampled every clock, timers advance only on tk.
// Ports   : clock / pclr_n (sync, active-low) / ptick / ptest / preq_a / preq_b in;
//           pgrn_*, pylw_*, pred_* lamps, pphase (state code), pmaxout (1-cycle pulse) out.
// Option  : TLC_PREEMPT_EN adds ppreempt (approach-A emergency) in and ppre_act out.
module tlc_phase_sched #(
  parameter int TW        = 6,
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 24,
  parameter int YELLOW    = 4,
  parameter int ALLRED    = 2
) (
  input  logic          clock,
  input  logic          pclr_n,
  input  logic          ptick,
  input  logic          ptest,
  input  logic          preq_a,
  input  logic          preq_b,
`ifdef TLC_PREEMPT_EN
  input  logic          ppreempt,
  output logic          ppre_act,
`endif
  output logic          pgrn_a,
  output logic          pylw_a,
  output logic          pred_a,
  output logic          pgrn_b,
  output logic          pylw_b,
  output logic          pred_b,
  output logic [2:0]    pphase,
  output logic          pmaxout
);

  localparam int TMAX_I = (1 << TW) - 1;

  if (TW < 1 || TW > 30 || MIN_GREEN < 1 || MIN_GREEN > MAX_GREEN || MAX_GREEN > TMAX_I ||
      YELLOW < 1 || YELLOW > TMAX_I || ALLRED < 1 || ALLRED > TMAX_I) begin : g_bad_param
    $error("tlc_phase_sched: timing parameter out of range for TW");
  end

  typedef enum logic [2:0] {
    AR_A  = 3'd0,
    GRN_A = 3'd1,
    YLW_A = 3'd2,
    AR_B  = 3'd3,
    GRN_B = 3'd4,
    YLW_B = 3'd5
  } state_t;

  localparam logic [TW-1:0] TMAX = '1;

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] timer;
  logic          call_a;
  logic          call_b;
  logic          maxout_d;
  logic          maxout_q;
  logic [5:0]    lamps_q;   // {grn_a, ylw_a, red_a, grn_b, ylw_b, red_b}
  logic          tk;
  logic          preempt;
  logic          el_min;
  logic          el_max;
  logic          el_yel;
  logic          el_ar;

  assign tk = ptick | ptest;

`ifdef TLC_PREEMPT_EN
  assign preempt  = ppreempt;
  assign ppre_act = ppreempt;
`else
  assign preempt  = 1'b0;
`endif

  // "n ticks elapsed" is timer+1 >= n; done one bit wider so a saturated
  // timer does not wrap to zero and lose an elapsed condition.
  function automatic logic elapsed(input logic [TW-1:0] t, input int n);
    logic [TW:0] tp1;
    tp1 = {1'b0, t} + {{TW{1'b0}}, 1'b1};
    return tp1 >= (TW+1)'(n);
  endfunction

  assign el_min = elapsed(timer, MIN_GREEN);
  assign el_max = elapsed(timer, MAX_GREEN);
  assign el_yel = elapsed(timer, YELLOW);
  assign el_ar  = elapsed(timer, ALLRED);

  function automatic logic [5:0] lamp_decode(input state_t s);
    logic [5:0] l;
    l = 6'b001_001;                 // all-red is the safe default
    case (s)
      GRN_A:   l = 6'b100_001;
      YLW_A:   l = 6'b010_001;
      GRN_B:   l = 6'b001_100;
      YLW_B:   l = 6'b001_010;
      default: l = 6'b001_001;
    endcase
    return l;
  endfunction

  always_comb begin
    state_d  = state_q;
    maxout_d = 1'b0;
    case (state_q)
      AR_A:  if (tk && el_ar) state_d = GRN_A;
      GRN_A: begin
        // Preemption favours A, so A green is held no matter what B wants.
        if (tk && !preempt && call_b) begin
          if (el_max) begin
            state_d  = YLW_A;
            maxout_d = 1'b1;        // max-out wins when gap-out is also eligible
          end else if (el_min && !preq_a) begin
            state_d  = YLW_A;
          end
        end
      end
      YLW_A: if (tk && el_yel) state_d = AR_B;
      AR_B:  if (tk && el_ar) state_d = GRN_B;
      GRN_B: begin
        if (tk) begin
          if (preempt) begin
            state_d = YLW_B;        // immediate, ignores min-green and calls
          end else if (call_a) begin
            if (el_max) begin
              state_d  = YLW_B;
              maxout_d = 1'b1;
            end else if (el_min && !preq_b) begin
              state_d  = YLW_B;
            end
          end
        end
      end
      YLW_B: if (tk && el_yel) state_d = AR_A;
      default: state_d = AR_B;      // illegal codes 6/7 recover unconditionally
    endcase
  end

  always_ff @(posedge clock) begin
    if (!pclr_n) begin
      state_q  <= AR_B;
      timer    <= '0;
      call_a   <= 1'b0;
      call_b   <= 1'b0;
      maxout_q <= 1'b0;
      lamps_q  <= 6'b001_001;
    end else begin
      state_q  <= state_d;
      maxout_q <= maxout_d;
      lamps_q  <= lamp_decode(state_d);

      if (state_d != state_q) begin
        timer <= '0;
      end else if (tk && timer != TMAX) begin
        timer <= timer + 1'b1;
      end

      // Clearing on green entry takes priority over a same-cycle set.
      if (state_d == GRN_A && state_q != GRN_A) begin
        call_a <= 1'b0;
      end else if (preq_a && state_q != GRN_A) begin
        call_a <= 1'b1;
      end

      if (state_d == GRN_B && state_q != GRN_B) begin
        call_b <= 1'b0;
      end else if (preq_b && state_q != GRN_B) begin
        call_b <= 1'b1;
      end
    end
  end

  assign pphase  = state_q;
  assign pmaxout = maxout_q;
  assign {pgrn_a, pylw_a, pred_a, pgrn_b, pylw_b, pred_b} = lamps_q;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// Directed, table-driven bench for tlc_phase_sched with default parameters
// (TW=6, MIN_GREEN=8, MAX_GREEN=24, YELLOW=4, ALLRED=2).
module tb_tlc_phase_sched;

  logic       clock;
  logic       pclr_n;
  logic       ptick;
  logic       ptest;
  logic       preq_a;
  logic       preq_b;
  logic       pgrn_a, pylw_a, pred_a, pgrn_b, pylw_b, pred_b;
  logic [2:0] pphase;
  logic       pmaxout;
`ifdef TLC_PREEMPT_EN
  logic       ppreempt;
  logic       ppre_act;
`endif

  int total = 0;
  int bad   = 0;

  tlc_phase_sched dut (
    .clock   (clock),
    .pclr_n  (pclr_n),
    .ptick   (ptick),
    .ptest   (ptest),
    .preq_a  (preq_a),
    .preq_b  (preq_b),
`ifdef TLC_PREEMPT_EN
    .ppreempt(ppreempt),
    .ppre_act(ppre_act),
`endif
    .pgrn_a  (pgrn_a),
    .pylw_a  (pylw_a),
    .pred_a  (pred_a),
    .pgrn_b  (pgrn_b),
    .pylw_b  (pylw_b),
    .pred_b  (pred_b),
    .pphase  (pphase),
    .pmaxout (pmaxout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst_n;
    logic       tick;
    logic       test;
    logic       req_a;
    logic       req_b;
    int         n;       // cycles this record is held and checked
    logic [2:0] ph;      // expected pphase after each of those edges
    logic       mo;      // expected pmaxout
    string      name;
  } vec_t;

  vec_t tab[$];

  // Lamp pattern {grn_a, ylw_a, red_a, grn_b, ylw_b, red_b} for a phase code.
  function automatic logic [5:0] lamps_of(input logic [2:0] ph);
    case (ph)
      3'd1:    return 6'b100_001;
      3'd2:    return 6'b010_001;
      3'd4:    return 6'b001_100;
      3'd5:    return 6'b001_010;
      default: return 6'b001_001;
    endcase
  endfunction

  task automatic add(input logic r, input logic t, input logic te, input logic a, input logic b,
                     input int n, input logic [2:0] ph, input logic mo, input string name);
    vec_t v;
    v.rst_n = r; v.tick = t; v.test = te; v.req_a = a; v.req_b = b;
    v.n = n; v.ph = ph; v.mo = mo; v.name = name;
    tab.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs sampled at the same point.
  task automatic step(input logic r, input logic t, input logic te, input logic a, input logic b);
    pclr_n = r; ptick = t; ptest = te; preq_a = a; preq_b = b;
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [2:0] ph, input logic mo);
    check(name, {6'd0, pphase, pgrn_a, pylw_a, pred_a, pgrn_b, pylw_b, pred_b, pmaxout},
                {6'd0, ph, lamps_of(ph), mo});
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int c = 0; c < tab[i].n; c++) begin
        step(tab[i].rst_n, tab[i].tick, tab[i].test, tab[i].req_a, tab[i].req_b);
        check_outs(tab[i].name, tab[i].ph, tab[i].mo);
      end
    end
  endtask

  initial begin
`ifdef TLC_PREEMPT_EN
    ppreempt = 1'b0;
`endif
    pclr_n = 1'b0; ptick = 1'b0; ptest = 1'b1; preq_a = 1'b0; preq_b = 1'b0;

    //  rst tk tst ra rb   n   ph  mo
    add(0, 0, 1, 0, 0,   2, 3'd3, 0, "reset_arb");        // 0
    add(1, 0, 1, 0, 0,   1, 3'd3, 0, "arb_clear");        // 1
    add(1, 0, 1, 0, 0,  70, 3'd4, 0, "grnb_hold_sat");    // 2  timer saturates at 63
    add(1, 0, 1, 1, 0,   1, 3'd4, 0, "grnb_call_a");      // 3
    add(1, 0, 1, 0, 0,   1, 3'd5, 1, "sat_maxout");       // 4
    add(1, 0, 1, 0, 0,   3, 3'd5, 0, "ylwb");             // 5
    add(1, 0, 1, 0, 0,   2, 3'd0, 0, "ara");              // 6
    add(1, 0, 1, 0, 0,   1, 3'd1, 0, "grna_t0");          // 7
    add(1, 0, 1, 0, 1,   1, 3'd1, 0, "grna_reqb_pulse");  // 8
    add(1, 0, 1, 0, 0,   6, 3'd1, 0, "grna_min");         // 9  8 green cycles in all
    add(1, 0, 1, 0, 0,   4, 3'd2, 0, "gapout_ylwa");      // 10
    add(1, 0, 1, 0, 0,   2, 3'd3, 0, "arb");              // 11
    add(1, 0, 1, 0, 0,   1, 3'd4, 0, "grnb_t0");          // 12
    add(1, 0, 1, 1, 1,   1, 3'd4, 0, "grnb_call_held");   // 13
    add(1, 0, 1, 0, 1,  22, 3'd4, 0, "grnb_to_max");      // 14 24 green cycles in all
    add(1, 0, 1, 0, 1,   1, 3'd5, 1, "maxout_pulse");     // 15
    add(1, 0, 1, 0, 1,   1, 3'd5, 0, "maxout_once");      // 16 call_b latched in YLW_B
    add(1, 0, 1, 0, 0,   2, 3'd5, 0, "ylwb2");            // 17
    add(1, 0, 1, 0, 0,   2, 3'd0, 0, "ara2");             // 18
    add(1, 0, 1, 0, 0,   1, 3'd1, 0, "grna2_t0");         // 19
    add(1, 0, 1, 0, 0,   7, 3'd1, 0, "grna2_min");        // 20
    add(1, 0, 1, 0, 0,   1, 3'd2, 0, "ylwa_t0");          // 21
    // after the slow-tick yellow, starting in AR_B at timer 0
    add(1, 0, 1, 0, 0,   1, 3'd3, 0, "arb3");             // 22
    add(1, 0, 1, 1, 0,   1, 3'd4, 0, "grnb3_call_a");     // 23
    add(1, 0, 1, 0, 0,   7, 3'd4, 0, "grnb3_min");        // 24
    add(1, 0, 1, 0, 0,   2, 3'd5, 0, "ylwb3");            // 25
    add(0, 0, 1, 1, 0,   1, 3'd3, 0, "reset_mid_ylwb");   // 26
    add(1, 0, 1, 0, 0,   1, 3'd3, 0, "arb_after_rst");    // 27
    add(1, 0, 1, 0, 0,  20, 3'd4, 0, "grnb_no_call");     // 28

    #1;
    run_range(0, 12);
    check("callb_cleared_on_entry", {15'd0, dut.call_b}, 16'd0);
    run_range(13, 21);

    // Slow timebase in YLW_A: tick every 5th cycle, timer frozen in between.
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        step(1, 0, 0, 0, 0);
        check("slow_hold", {7'd0, pphase, dut.timer}, {7'd0, 3'd2, 6'(k)});
      end
      step(1, 1, 0, 0, 0);
      if (k < 3) check("slow_tick", {7'd0, pphase, dut.timer}, {7'd0, 3'd2, 6'(k + 1)});
      else       check("slow_to_arb", {7'd0, pphase, dut.timer}, {7'd0, 3'd3, 6'd0});
    end

    run_range(22, 26);
    check("calls_cleared_by_reset", {14'd0, dut.call_a, dut.call_b}, 16'd0);
    run_range(27, 28);

`ifdef TLC_PREEMPT_EN
    step(0, 0, 1, 0, 0);
    check_outs("pre_reset", 3'd3, 1'b0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    check("pre_grnb_t1", {7'd0, pphase, dut.timer}, {7'd0, 3'd4, 6'd1});
    ppreempt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 1, 0, 1);
      check_outs("pre_ylwb", 3'd5, 1'b0);
      check("pre_act", {15'd0, ppre_act}, 16'd1);
    end
    for (int c = 0; c < 2; c++) begin
      step(1, 0, 1, 0, 1);
      check_outs("pre_ara", 3'd0, 1'b0);
    end
    for (int c = 0; c < 51; c++) begin
      step(1, 0, 1, 0, 1);
      check_outs("pre_grna_held", 3'd1, 1'b0);
      check("pre_act_hold", {15'd0, ppre_act}, 16'd1);
    end
    ppreempt = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
